regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port (Reg_write/Write_reg/Write_data) between two

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters (0 = ALU result, 1 = memory load). On a conflict the grant
//   alternates round-robin. The write port is driven from flops, so an
//   accepted write reaches the register file one edge after acceptance.
//   A busy scoreboard tracks destinations that have been issued but not yet
//   retired, so decode can stall on a pending write.
//
// Ports:
//   Clk, Rst                 clock (posedge) / asynchronous active-high reset
//   Req0_valid/_reg/_data    ALU writeback request
//   Req0_ready               combinational grant to requester 0
//   Req1_valid/_reg/_data    load writeback request
//   Req1_ready               combinational grant to requester 1
//   Issue_valid/Issue_reg    decode issued an instruction writing Issue_reg
//   Reg_write                register-file write enable (registered)
//   Write_reg                register-file write index (registered)
//   Write_data               register-file write data (registered)
//   Busy_mask                bit i set: register i has a write pending
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0_valid,
  input  logic [ADDR_W-1:0] Req0_reg,
  input  logic [DATA_W-1:0] Req0_data,
  output logic              Req0_ready,
  input  logic              Req1_valid,
  input  logic [ADDR_W-1:0] Req1_reg,
  input  logic [DATA_W-1:0] Req1_data,
  output logic              Req1_ready,
  input  logic              Issue_valid,
  input  logic [ADDR_W-1:0] Issue_reg,
  output logic              Reg_write,
  output logic [ADDR_W-1:0] Write_reg,
  output logic [DATA_W-1:0] Write_data,
  output logic [NREG-1:0]   Busy_mask
);

  // Identity of the requester that won the most recent transfer.
  localparam logic [0:0] GRANT_REQ0 = 1'b0;
  localparam logic [0:0] GRANT_REQ1 = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic              reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   busy_q,       busy_d;

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone request is always granted; on a tie the requester
  // that did not win last time gets the port.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (Req0_valid && Req1_valid) begin
      if (last_grant_q == GRANT_REQ1) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = Req0_valid;
      grant1 = Req1_valid;
    end
  end

  assign xfer     = grant0 | grant1;
  assign win_reg  = grant1 ? Req1_reg  : Req0_reg;
  assign win_data = grant1 ? Req1_data : Req0_data;

  assign Req0_ready = grant0;
  assign Req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Output stage. Writes to register 0 are handshaken normally but never
  // raise the write enable. Index/data hold when idle so the port only
  // toggles on real traffic.
  // ---------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (xfer) begin
      last_grant_d = grant1 ? GRANT_REQ1 : GRANT_REQ0;
      reg_write_d  = (win_reg != '0);
      write_reg_d  = win_reg;
      write_data_d = win_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. A write retires on the edge that ends its Reg_write
  // cycle. If decode re-issues the same destination on that edge, the new
  // issue keeps the bit set. Register 0 is never tracked.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_d[gi] = 1'b0;
      end else begin : g_bit
        logic set_bit;
        logic clr_bit;
        assign set_bit    = Issue_valid && (Issue_reg == ADDR_W'(gi));
        assign clr_bit    = reg_write_q && (write_reg_q == ADDR_W'(gi));
        assign busy_d[gi] = set_bit | (busy_q[gi] & ~clr_bit);
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State. Reset drops any in-flight write immediately and makes requester 0
  // the winner of the first tie.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      last_grant_q <= GRANT_REQ1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign Reg_write  = reg_write_q;
  assign Write_reg  = write_reg_q;
  assign Write_data = write_data_q;
  assign Busy_mask  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed scenarios followed by a randomized run. A behavioural model
// (expected grant, expected write port contents, expected busy bits) is
// advanced once per clock and compared against the design.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        Clk;
  logic        Rst;
  logic        Req0_valid;
  logic [4:0]  Req0_reg;
  logic [31:0] Req0_data;
  logic        Req0_ready;
  logic        Req1_valid;
  logic [4:0]  Req1_reg;
  logic [31:0] Req1_data;
  logic        Req1_ready;
  logic        Issue_valid;
  logic [4:0]  Issue_reg;
  logic        Reg_write;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [31:0] Busy_mask;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Req0_valid (Req0_valid),
    .Req0_reg   (Req0_reg),
    .Req0_data  (Req0_data),
    .Req0_ready (Req0_ready),
    .Req1_valid (Req1_valid),
    .Req1_reg   (Req1_reg),
    .Req1_data  (Req1_data),
    .Req1_ready (Req1_ready),
    .Issue_valid(Issue_valid),
    .Issue_reg  (Issue_reg),
    .Reg_write  (Reg_write),
    .Write_reg  (Write_reg),
    .Write_data (Write_data),
    .Busy_mask  (Busy_mask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int          m_last;     // requester that won the latest transfer
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_busy;
  logic        g0;         // model grant of the most recent step
  logic        g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    Req0_valid = 1'b0; Req0_reg = '0; Req0_data = '0;
    Req1_valid = 1'b0; Req1_reg = '0; Req1_data = '0;
    Issue_valid = 1'b0; Issue_reg = '0;
  endtask

  // Asserts reset away from any clock edge, checks the immediate effect,
  // then releases it and leaves the bench one step after a posedge.
  task automatic do_reset(input string tag);
    idle_inputs();
    Rst = 1'b1;
    #1;
    chk({tag, "_rst_reg_write"},  {31'd0, Reg_write}, 32'd0);
    chk({tag, "_rst_write_reg"},  {27'd0, Write_reg}, 32'd0);
    chk({tag, "_rst_write_data"}, Write_data, 32'd0);
    chk({tag, "_rst_busy"},       Busy_mask, 32'd0);
    m_last = 1; m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_busy = '0;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  // One clock of traffic with the currently driven inputs.
  task automatic step(input string tag);
    int          winner;
    logic [4:0]  wr;
    logic [31:0] wd;
    @(negedge Clk);
    winner = -1;
    if (Req0_valid && Req1_valid) winner = (m_last == 0) ? 1 : 0;
    else if (Req0_valid)          winner = 0;
    else if (Req1_valid)          winner = 1;
    g0 = (winner == 0);
    g1 = (winner == 1);
    chk({tag, "_ready0"}, {31'd0, Req0_ready}, {31'd0, g0});
    chk({tag, "_ready1"}, {31'd0, Req1_ready}, {31'd0, g1});
    wr = (winner == 1) ? Req1_reg  : Req0_reg;
    wd = (winner == 1) ? Req1_data : Req0_data;
    @(posedge Clk);
    #1;
    // Retire the write that was on the port during the finished cycle,
    // then record new issues (a same-edge issue wins).
    if (m_rw) m_busy[m_wreg] = 1'b0;
    if (Issue_valid && Issue_reg != 0) m_busy[Issue_reg] = 1'b1;
    if (winner >= 0) begin
      m_last  = winner;
      m_rw    = (wr != 0);
      m_wreg  = wr;
      m_wdata = wd;
    end else begin
      m_rw = 1'b0;
    end
    chk({tag, "_reg_write"},  {31'd0, Reg_write}, {31'd0, m_rw});
    chk({tag, "_write_reg"},  {27'd0, Write_reg}, {27'd0, m_wreg});
    chk({tag, "_write_data"}, Write_data, m_wdata);
    chk({tag, "_busy"},       Busy_mask, m_busy);
    $display("step %-10s r0=%b/%0d r1=%b/%0d iss=%b/%0d -> we=%b wr=%0d wd=%h busy=%h",
             tag, g0, Req0_reg, g1, Req1_reg, Issue_valid, Issue_reg,
             Reg_write, Write_reg, Write_data, Busy_mask);
  endtask

  initial begin
    logic [4:0] exp_seq [4];
    bit r0_pend;
    bit r1_pend;
    exp_seq[0] = 5'd3; exp_seq[1] = 5'd4; exp_seq[2] = 5'd3; exp_seq[3] = 5'd4;

    Rst = 1'b0;
    idle_inputs();
    #2;

    // 1: reset, then a single ALU write
    do_reset("t1");
    Req0_valid = 1'b1; Req0_reg = 5'd5; Req0_data = 32'hA5;
    step("t1_write");
    chk("t1_we_const",   {31'd0, Reg_write}, 32'd1);
    chk("t1_reg_const",  {27'd0, Write_reg}, 32'd5);
    chk("t1_data_const", Write_data, 32'hA5);
    idle_inputs();

    // 2: tie after reset goes to requester 0, then alternates
    do_reset("t2");
    Req0_valid = 1'b1; Req0_reg = 5'd3; Req0_data = 32'h33;
    Req1_valid = 1'b1; Req1_reg = 5'd4; Req1_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      step("t2_tie");
      chk("t2_alt_reg", {27'd0, Write_reg}, {27'd0, exp_seq[i]});
    end
    idle_inputs();

    // 3: write to register 0 is granted but dropped
    Req1_valid = 1'b1; Req1_reg = 5'd0; Req1_data = 32'hFFFF_FFFF;
    step("t3_r0wr");
    chk("t3_we_zero", {31'd0, Reg_write}, 32'd0);
    chk("t3_busy",    Busy_mask, 32'd0);
    idle_inputs();

    // 5: issuing register 0 never marks it busy
    Issue_valid = 1'b1; Issue_reg = 5'd0;
    step("t5_iss0");
    chk("t5_busy", Busy_mask, 32'd0);
    idle_inputs();

    // 4: scoreboard set / retire / same-edge set wins
    Issue_valid = 1'b1; Issue_reg = 5'd7;
    step("t4_iss7");
    chk("t4_set7", Busy_mask, 32'h80);
    idle_inputs();
    Req0_valid = 1'b1; Req0_reg = 5'd7; Req0_data = 32'h77;
    step("t4_wr7");
    chk("t4_pending7", Busy_mask, 32'h80);
    idle_inputs();
    step("t4_ret7");
    chk("t4_clr7", Busy_mask, 32'd0);
    Issue_valid = 1'b1; Issue_reg = 5'd7;
    step("t4_iss7b");
    idle_inputs();
    Req0_valid = 1'b1; Req0_reg = 5'd7; Req0_data = 32'h78;
    step("t4_wr7b");
    idle_inputs();
    Issue_valid = 1'b1; Issue_reg = 5'd7;
    step("t4_same");
    chk("t4_setwins", Busy_mask, 32'h80);
    idle_inputs();
    Req0_valid = 1'b1; Req0_reg = 5'd9; Req0_data = 32'h99;
    step("t6_wr9");
    chk("t6_pre_we",   {31'd0, Reg_write}, 32'd1);
    chk("t6_pre_busy", Busy_mask, 32'h80);

    // 6: reset mid-operation, effective without a clock edge
    #2;
    do_reset("t6");

    // Randomized traffic: requesters hold until granted
    r0_pend = 0;
    r1_pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!r0_pend && $urandom_range(0, 1) == 1) begin
        r0_pend = 1;
        Req0_valid = 1'b1;
        Req0_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        Req0_data = $urandom;
      end
      if (!r1_pend && $urandom_range(0, 1) == 1) begin
        r1_pend = 1;
        Req1_valid = 1'b1;
        Req1_reg = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        Req1_data = $urandom;
      end
      Issue_valid = 1'($urandom_range(0, 1));
      Issue_reg   = 5'($urandom_range(0, 31));
      step("rand");
      if (g0) begin r0_pend = 0; Req0_valid = 1'b0; end
      if (g1) begin r1_pend = 0; Req1_valid = 1'b0; end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
